log2_seq: RTL and testbench



---
 rtl/log2_pkg.sv | 22 ++
 rtl/lead_one_detect.sv | 26 ++
 rtl/log2_seq.sv | 149 ++++++++++++++
 tb/tb_log2_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/log2_pkg.sv
// log2_pkg: shared types and helpers for the sequential base-2 logarithm unit.
//   log2_state_t : FSM states IDLE, NORM, FRAC, DONE
//   FRAC_EN      : 1 when the fractional refinement is built (LOG2_FRAC_EN defined)
//   res_w()      : result width for a given operand width and fraction length
// Optional feature macro: LOG2_FRAC_EN
package log2_pkg;

    typedef enum logic [1:0] {IDLE, NORM, FRAC, DONE} log2_state_t;

`ifdef LOG2_FRAC_EN
    localparam bit FRAC_EN = 1'b1;
`else
    localparam bit FRAC_EN = 1'b0;
`endif

    // Integer field is always $clog2(width) bits; the fraction is appended only
    // when the refinement hardware exists.
    function automatic int res_w(input int width, input int frac_bits);
        return $clog2(width) + (FRAC_EN ? frac_bits : 0);
    endfunction

endpackage

// File: rtl/lead_one_detect.sv
// lead_one_detect: combinational WIDTH-bit priority encoder (integer log2).
//   a_i       in  WIDTH  operand
//   idx_o     out IW     index of the highest set bit (0 when a_i == 0)
//   nonzero_o out 1      a_i has at least one set bit
import log2_pkg::*;

module lead_one_detect #(
    parameter  int WIDTH = 32,
    localparam int IW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a_i,
    output logic [IW-1:0]    idx_o,
    output logic             nonzero_o
);

    // Ascending scan: the last set bit seen is the most significant one.
    always_comb begin
        idx_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a_i[i]) idx_o = IW'(i);
        end
    end

    assign nonzero_o = |a_i;

endmodule

// File: rtl/log2_seq.sv
// log2_seq: sequential floor(log2(A)) with optional fixed-point fraction.
// Optional feature macro: LOG2_FRAC_EN (adds FRAC state, squarer, counter and
// FRAC_BITS fraction bits below the integer part of the result).
//   clk       in  1      clock, rising edge
//   rst       in  1      synchronous active-high reset
//   in_valid  in  1      operand valid
//   in_ready  out 1      unit can accept an operand
//   A         in  WIDTH  unsigned operand
//   out_valid out 1      result valid
//   out_ready in  1      consumer accepts result
//   log2      out RES_W  {integer part, fraction}
//   zero      out 1      operand was zero (result forced to 0)
import log2_pkg::*;

module log2_seq #(
    parameter  int WIDTH     = 32,
    parameter  int FRAC_BITS = 4,
    parameter  int MANT_W    = 16,
    localparam int RES_W     = res_w(WIDTH, FRAC_BITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] log2,
    output logic             zero
);

    localparam int IW = $clog2(WIDTH);

    if ((WIDTH & (WIDTH - 1)) != 0 || WIDTH < 4 ||
        (FRAC_EN && (FRAC_BITS < 1 || MANT_W < FRAC_BITS + 2))) begin : g_bad_cfg
        $error("log2_seq: illegal WIDTH/FRAC_BITS/MANT_W combination");
    end

    log2_state_t      state_q;
    logic [WIDTH-1:0] a_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             zero_q;
    logic [RES_W-1:0] log2_q;
    logic [IW-1:0]    lead_idx;
    logic             lead_nz;
    logic             accept;
    logic             release_res;

    lead_one_detect #(.WIDTH(WIDTH)) u_lod (
        .a_i       (a_q),
        .idx_o     (lead_idx),
        .nonzero_o (lead_nz)
    );

    assign accept      = in_valid && in_ready_q;
    assign release_res = out_valid_q && out_ready;

`ifdef LOG2_FRAC_EN
    localparam int CW = $clog2(FRAC_BITS + 1);

    logic [MANT_W-1:0]   mant_q;
    logic [MANT_W-1:0]   mant_nrm_d;
    logic [MANT_W-1:0]   mant_sq_d;
    logic [2*MANT_W-1:0] sq;
    logic                sq_bit;
    logic [FRAC_BITS-1:0] frac_d;
    logic [CW-1:0]       cnt_q;

    always_comb begin
        // Left-justify the operand so its leading one sits at the MSB, then keep
        // the top MANT_W bits (zero-padded if the operand is narrower).
        mant_nrm_d = MANT_W'(({a_q, {MANT_W{1'b0}}} << (IW'(WIDTH - 1) - lead_idx)) >> WIDTH);
        sq         = (2*MANT_W)'(mant_q) * (2*MANT_W)'(mant_q);
        // m in [1,2) gives m^2 in [1,4): the top bit says whether the square
        // crossed 2, which is the next fraction bit; renormalise by truncation.
        sq_bit     = sq[2*MANT_W-1];
        mant_sq_d  = sq_bit ? MANT_W'(sq >> MANT_W) : MANT_W'(sq >> (MANT_W - 1));
        frac_d     = FRAC_BITS'({log2_q[FRAC_BITS-1:0], sq_bit});
    end
`endif

    // Operand and mantissa datapath registers carry no reset.
    always_ff @(posedge clk) begin
        if (accept) a_q <= A;
`ifdef LOG2_FRAC_EN
        if (state_q == NORM)      mant_q <= mant_nrm_d;
        else if (state_q == FRAC) mant_q <= mant_sq_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            log2_q      <= '0;
            zero_q      <= 1'b0;
`ifdef LOG2_FRAC_EN
            cnt_q       <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        state_q    <= NORM;
                    end
                end
                NORM: begin
                    zero_q <= !lead_nz;
`ifdef LOG2_FRAC_EN
                    log2_q  <= {lead_idx, FRAC_BITS'(0)};
                    cnt_q   <= '0;
                    state_q <= lead_nz ? FRAC : DONE;
`else
                    log2_q  <= lead_idx;
                    state_q <= DONE;
`endif
                end
`ifdef LOG2_FRAC_EN
                FRAC: begin
                    log2_q <= {log2_q[RES_W-1 -: IW], frac_d};
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == CW'(FRAC_BITS - 1)) state_q <= DONE;
                end
`endif
                DONE: begin
                    // out_valid rises one cycle after entering DONE, so the
                    // result registers have settled before it is offered.
                    if (release_res) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign log2      = log2_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_log2_seq.sv
// tb_log2_seq: scoreboard bench for log2_seq (WIDTH=32, FRAC_BITS=4, MANT_W=16).
// Builds with or without LOG2_FRAC_EN; expected values adapt to the build.
module tb_log2_seq;

`ifdef LOG2_FRAC_EN
    localparam int RES_W = 9;
    localparam int LAT   = 6;
`else
    localparam int RES_W = 5;
    localparam int LAT   = 2;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [31:0]      A = '0;
    logic             in_ready;
    logic             out_valid;
    logic             zero;
    logic [RES_W-1:0] log2;

    log2_seq #(.WIDTH(32), .FRAC_BITS(4), .MANT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .log2      (log2),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [RES_W-1:0] l;
        logic             z;
    } exp_t;

    exp_t sb[$];
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    // Reference: highest set bit, then four truncating squarings of a Q1.15 mantissa.
    function automatic logic [8:0] ref_full(input logic [31:0] a);
        int          p;
        bit          found;
        logic [63:0] t;
        logic [15:0] m;
        logic [31:0] sq;
        logic [3:0]  fr;
        p = 0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && a[i]) begin
                p = i;
                found = 1'b1;
            end
        end
        t  = {32'b0, a} << (31 - p);
        m  = t[31:16];
        fr = '0;
        if (a != 0) begin
            for (int k = 0; k < 4; k++) begin
                sq = 32'(m) * 32'(m);
                fr = {fr[2:0], sq[31]};
                m  = sq[31] ? sq[31:16] : sq[30:15];
            end
        end
        return {p[4:0], fr};
    endfunction

    // Reduce a full 9-bit {int,frac} value to what this build produces.
    function automatic logic [RES_W-1:0] scale(input logic [8:0] full);
`ifdef LOG2_FRAC_EN
        return full;
`else
        return full[8:4];
`endif
    endfunction

    function automatic exp_t expect_of(input logic [31:0] a);
        exp_t e;
        e.l = scale(ref_full(a));
        e.z = (a == 0);
        return e;
    endfunction

    // Drive one operand (bounded wait for in_ready), push its expectation.
    task automatic send(input logic [31:0] a);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        A = a;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        sb.push_back(expect_of(a));
    endtask

    // Cycles from the accept edge until out_valid is seen (capped at 64).
    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 64) begin
            @(posedge clk); #1; cyc++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        cmp_cnt++; if (log2 !== '0) begin err_cnt++; $display("FAIL reset_log2 got %h want 0", log2); end
        cmp_cnt++; if (zero !== 1'b0) begin err_cnt++; $display("FAIL reset_zero got %b want 0", zero); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_values();
        logic [31:0] va [5] = '{32'h1, 32'h8, 32'h8000_0000, 32'h3, 32'hFFFF_FFFF};
        logic [8:0]  vf [5] = '{9'h000, 9'h030, 9'h1F0, 9'h019, 9'h1FF};
        int   cyc;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            send(va[i]);
            wait_out(cyc);
            e = sb.pop_front();
            cmp_cnt++; if (cyc != LAT) begin err_cnt++; $display("FAIL value_latency A=%h got %0d want %0d", va[i], cyc, LAT); end
            cmp_cnt++; if (log2 !== scale(vf[i])) begin err_cnt++; $display("FAIL value_log2 A=%h got %h want %h", va[i], log2, scale(vf[i])); end
            cmp_cnt++; if (zero !== e.z) begin err_cnt++; $display("FAIL value_zero A=%h got %b want %b", va[i], zero, e.z); end
            handshake();
        end
    endtask

    task automatic test_zero();
        int   cyc;
        exp_t e;
        send(32'h0);
        wait_out(cyc);
        e = sb.pop_front();
        cmp_cnt++; if (cyc != 2) begin err_cnt++; $display("FAIL zero_latency got %0d want 2", cyc); end
        cmp_cnt++; if (log2 !== '0) begin err_cnt++; $display("FAIL zero_log2 got %h want 0", log2); end
        cmp_cnt++; if (zero !== 1'b1) begin err_cnt++; $display("FAIL zero_flag got %b want 1", zero); end
        handshake();
    endtask

    task automatic test_backpressure();
        int   cyc;
        exp_t e;
        send(32'h5);
        wait_out(cyc);
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            cmp_cnt++; if (out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_out_valid cyc=%0d got %b want 1", i, out_valid); end
            cmp_cnt++; if (log2 !== scale(9'h025)) begin err_cnt++; $display("FAIL bp_log2 cyc=%0d got %h want %h", i, log2, scale(9'h025)); end
            cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_in_ready cyc=%0d got %b want 0", i, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_hs_in_ready got %b want 0", in_ready); end
        cmp_cnt++; if (zero !== e.z) begin err_cnt++; $display("FAIL bp_zero got %b want %b", zero, e.z); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_post_in_ready got %b want 1", in_ready); end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL bp_post_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_midop();
        int   cyc;
        int   spurious = 0;
        exp_t e;
        send(32'h7);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
        cmp_cnt++; if (log2 !== '0) begin err_cnt++; $display("FAIL rmid_log2 got %h want 0", log2); end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b0) spurious++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        cmp_cnt++; if (spurious != 0) begin err_cnt++; $display("FAIL rmid_no_result got %0d valid cycles want 0", spurious); end
        send(32'h10);
        wait_out(cyc);
        e = sb.pop_front();
        cmp_cnt++; if (cyc != LAT) begin err_cnt++; $display("FAIL rmid_fresh_latency got %0d want %0d", cyc, LAT); end
        cmp_cnt++; if (log2 !== scale(9'h040)) begin err_cnt++; $display("FAIL rmid_fresh_log2 got %h want %h", log2, scale(9'h040)); end
        cmp_cnt++; if (zero !== e.z) begin err_cnt++; $display("FAIL rmid_fresh_zero got %b want %b", zero, e.z); end
        handshake();
    endtask

    // out_ready held high throughout, including while no result is valid.
    task automatic test_back_to_back();
        int          cyc;
        exp_t        e;
        logic [31:0] a;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            a = (i % 5 == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 31));
            send(a);
            wait_out(cyc);
            e = sb.pop_front();
            cmp_cnt++; if (cyc != ((a == 0) ? 2 : LAT)) begin err_cnt++; $display("FAIL b2b_latency A=%h got %0d", a, cyc); end
            cmp_cnt++; if (log2 !== e.l || zero !== e.z) begin err_cnt++; $display("FAIL b2b_result A=%h got %h/%b want %h/%b", a, log2, zero, e.l, e.z); end
            @(posedge clk); #1;
            cmp_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_release A=%h got ov=%b ir=%b want 0/1", a, out_valid, in_ready); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int          cyc;
        exp_t        e;
        logic [31:0] a;
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0:       a = $urandom;
                1:       a = $urandom >> $urandom_range(0, 31);
                2:       a = 32'h1 << $urandom_range(0, 31);
                default: a = $urandom_range(0, 3);
            endcase
            send(a);
            wait_out(cyc);
            e = sb.pop_front();
            cmp_cnt++; if (cyc != ((a == 0) ? 2 : LAT)) begin err_cnt++; $display("FAIL rnd_latency A=%h got %0d", a, cyc); end
            cmp_cnt++; if (log2 !== e.l) begin err_cnt++; $display("FAIL rnd_log2 A=%h got %h want %h", a, log2, e.l); end
            cmp_cnt++; if (zero !== e.z) begin err_cnt++; $display("FAIL rnd_zero A=%h got %b want %b", a, zero, e.z); end
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            handshake();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_values();
        test_zero();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
